// File: rtl/fa_pipe_nbit.sv
// Segmented pipelined adder/subtractor: SEG_W bits per stage, valid/ready handshake on both sides.
// Define FA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module fa_pipe_nbit #(
   parameter int WIDTH = 16,
   parameter int SEG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
`ifdef FA_PIPE_OVF_EN
   output logic             ovf,
`endif
   output logic             co
);

   localparam int STAGES = WIDTH / SEG_W;

   logic             adv;

   // Per-stage registers; a_reg/b_reg hold the not-yet-added operand bits,
   // shifted down so the next stage always finds its segment in the low bits.
   logic [WIDTH-1:0] sum_reg   [STAGES];
   logic [WIDTH-1:0] a_reg     [STAGES];
   logic [WIDTH-1:0] b_reg     [STAGES];
   logic             carry_reg [STAGES];
   logic             valid_reg [STAGES];

   logic [WIDTH-1:0] sum_next   [STAGES];
   logic [WIDTH-1:0] a_next     [STAGES];
   logic [WIDTH-1:0] b_next     [STAGES];
   logic             carry_next [STAGES];

`ifdef FA_PIPE_OVF_EN
   logic             sa_reg  [STAGES];
   logic             sb_reg  [STAGES];
   logic             sa_next [STAGES];
   logic             sb_next [STAGES];
   logic             ovf_reg;
   logic             ovf_next;
`endif

   assign adv       = !valid_reg[STAGES-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = valid_reg[STAGES-1];
   assign s         = sum_reg[STAGES-1];
   assign co        = carry_reg[STAGES-1];

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_W{1'b1}}) << (gi * SEG_W);

      logic [WIDTH-1:0] op_a;
      logic [WIDTH-1:0] op_b;
      logic [WIDTH-1:0] part_s;
      logic             c_in;
      logic [SEG_W:0]   seg_sum;

      if (gi == 0) begin : g_head
         // Subtract is a + ~b + 1: invert b once here and force the carry in.
         assign op_a   = a;
         assign op_b   = sub ? ~b : b;
         assign c_in   = sub ? 1'b1 : ci;
         assign part_s = '0;
`ifdef FA_PIPE_OVF_EN
         assign sa_next[gi] = a[WIDTH-1];
         assign sb_next[gi] = sub ? ~b[WIDTH-1] : b[WIDTH-1];
`endif
      end else begin : g_body
         assign op_a   = a_reg[gi-1];
         assign op_b   = b_reg[gi-1];
         assign c_in   = carry_reg[gi-1];
         assign part_s = sum_reg[gi-1];
`ifdef FA_PIPE_OVF_EN
         assign sa_next[gi] = sa_reg[gi-1];
         assign sb_next[gi] = sb_reg[gi-1];
`endif
      end

      assign seg_sum        = {1'b0, op_a[SEG_W-1:0]} + {1'b0, op_b[SEG_W-1:0]}
                            + (SEG_W+1)'(c_in);
      assign sum_next[gi]   = (part_s & ~SEG_MASK)
                            | ((WIDTH'(seg_sum[SEG_W-1:0]) << (gi * SEG_W)) & SEG_MASK);
      assign carry_next[gi] = seg_sum[SEG_W];
      assign a_next[gi]     = op_a >> SEG_W;
      assign b_next[gi]     = op_b >> SEG_W;
   end

`ifdef FA_PIPE_OVF_EN
   assign ovf_next = (sa_next[STAGES-1] == sb_next[STAGES-1])
                  && (sum_next[STAGES-1][WIDTH-1] != sa_next[STAGES-1]);
   assign ovf      = ovf_reg;
`endif

   // All stages move together; a stalled output freezes the whole pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_reg[k] <= 1'b0;
            sum_reg[k]   <= '0;
            a_reg[k]     <= '0;
            b_reg[k]     <= '0;
            carry_reg[k] <= 1'b0;
`ifdef FA_PIPE_OVF_EN
            sa_reg[k]    <= 1'b0;
            sb_reg[k]    <= 1'b0;
`endif
         end
`ifdef FA_PIPE_OVF_EN
         ovf_reg <= 1'b0;
`endif
      end else if (adv) begin
         valid_reg[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            valid_reg[k] <= valid_reg[k-1];
         end
         for (int k = 0; k < STAGES; k++) begin
            sum_reg[k]   <= sum_next[k];
            a_reg[k]     <= a_next[k];
            b_reg[k]     <= b_next[k];
            carry_reg[k] <= carry_next[k];
`ifdef FA_PIPE_OVF_EN
            sa_reg[k]    <= sa_next[k];
            sb_reg[k]    <= sb_next[k];
`endif
         end
`ifdef FA_PIPE_OVF_EN
         ovf_reg <= ovf_next;
`endif
      end
   end

endmodule

// File: tb/tb_fa_pipe_nbit.sv
// Testbench for fa_pipe_nbit: directed corner cases plus randomized traffic against a queue-based model.
// Covers both the default 16/4 configuration and an 8/8 single-stage instance; honours FA_PIPE_OVF_EN.
module tb_fa_pipe_nbit;

   localparam int W      = 16;
   localparam int STAGES = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, ci, sub, out_valid, out_ready, co;
   logic [W-1:0]  a, b, s;
   logic          ovf;

   logic          n8_in_valid, n8_in_ready, n8_ci, n8_sub, n8_out_valid, n8_out_ready, n8_co;
   logic [7:0]    n8_a, n8_b, n8_s;
   logic          n8_ovf;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ovf;
   } res_t;

   res_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_out    = 0;

   always #5 clk = ~clk;

   fa_pipe_nbit #(.WIDTH(16), .SEG_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .s(s),
`ifdef FA_PIPE_OVF_EN
      .ovf(ovf),
`endif
      .co(co)
   );

   fa_pipe_nbit #(.WIDTH(8), .SEG_W(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(n8_in_valid), .in_ready(n8_in_ready),
      .a(n8_a), .b(n8_b), .ci(n8_ci), .sub(n8_sub),
      .out_valid(n8_out_valid), .out_ready(n8_out_ready), .s(n8_s),
`ifdef FA_PIPE_OVF_EN
      .ovf(n8_ovf),
`endif
      .co(n8_co)
   );

`ifndef FA_PIPE_OVF_EN
   assign ovf    = 1'b0;
   assign n8_ovf = 1'b0;
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Plain-arithmetic reference: full-width add of a and (b or ~b) with carry.
   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mci, input logic msub);
      res_t         r;
      logic [W:0]   t;
      logic [W-1:0] be;
      be    = msub ? ~mb : mb;
      t     = {1'b0, ma} + {1'b0, be} + (W+1)'(msub ? 1'b1 : mci);
      r.s   = t[W-1:0];
      r.co  = t[W];
      r.ovf = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
      return r;
   endfunction

   // Scoreboard: inputs and outputs stable at negedge describe the upcoming edge.
   always @(negedge clk) begin
      res_t r;
      if (rst) begin
         exp_q.delete();
      end else begin
         check_eq("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
         if (out_valid && out_ready) begin
            check_eq("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               r = exp_q.pop_front();
               check_eq("out_s", 32'(s), 32'(r.s));
               check_eq("out_co", 32'(co), 32'(r.co));
`ifdef FA_PIPE_OVF_EN
               check_eq("out_ovf", 32'(ovf), 32'(r.ovf));
`endif
               n_out++;
               $display("txn %0d: s=%h co=%b ovf=%b", n_out, s, co, ovf);
            end
         end else if (out_valid && exp_q.size() != 0) begin
            check_eq("hold_s", 32'(s), 32'(exp_q[0].s));
            check_eq("hold_co", 32'(co), 32'(exp_q[0].co));
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
      end
   end

   // Presents one operand set and leaves the result sitting at the output.
   task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tci, input logic tsub,
                          input logic [W-1:0] es, input logic eco);
      int cyc;
      a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 32) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq({tag, "_latency"}, 32'(cyc), 32'(STAGES));
      check_eq({tag, "_s"}, 32'(s), 32'(es));
      check_eq({tag, "_co"}, 32'(co), 32'(eco));
   endtask

   task automatic drain();
      int k;
      in_valid = 1'b0; out_ready = 1'b1; k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 64) begin
         @(posedge clk); #1;
         k++;
      end
      check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, seen, k;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
      n8_in_valid = 1'b0; n8_a = '0; n8_b = '0; n8_ci = 1'b0; n8_sub = 1'b0; n8_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_s", 32'(s), 32'd0);
      check_eq("rst_co", 32'(co), 32'd0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);
      check_eq("rst8_s", 32'(n8_s), 32'd0);
      rst = 1'b0;

      // Single-stage instance: result one cycle after acceptance.
      n8_a = 8'h80; n8_b = 8'h80; n8_ci = 1'b1; n8_sub = 1'b0; n8_in_valid = 1'b1;
      @(posedge clk); #1;
      n8_in_valid = 1'b0;
      check_eq("w8_valid", 32'(n8_out_valid), 32'd1);
      check_eq("w8_s", 32'(n8_s), 32'h01);
      check_eq("w8_co", 32'(n8_co), 32'd1);
      n8_a = 8'h10; n8_b = 8'h20; n8_ci = 1'b1; n8_sub = 1'b1; n8_in_valid = 1'b1;
      @(posedge clk); #1;
      n8_in_valid = 1'b0;
      check_eq("w8_sub_s", 32'(n8_s), 32'hF0);
      check_eq("w8_sub_co", 32'(n8_co), 32'd0);

      run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
      run_one("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0);
`ifdef FA_PIPE_OVF_EN
      run_one("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
      check_eq("ovf_add_flag", 32'(ovf), 32'd1);
      run_one("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
      check_eq("ovf_sub_flag", 32'(ovf), 32'd1);
`endif
      drain();

      // Six back-to-back inputs, then a three-cycle output stall.
      base = n_out;
      for (int i = 0; i < 6; i++) begin
         a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_eq("stall_in_ready", 32'(in_ready), 32'd0);
         check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      end
      drain();
      check_eq("b2b_count", 32'(n_out - base), 32'd6);

      // Reset with three results in flight; none may surface later.
      for (int i = 0; i < 3; i++) begin
         a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'b0;
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      rst = 1'b1; a = 16'h1234;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      check_eq("rst_flush_valid", 32'(out_valid), 32'd0);
      base = n_out; seen = 0;
      for (k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check_eq("rst_no_stale", 32'(seen), 32'd0);
      check_eq("rst_no_stale_out", 32'(n_out - base), 32'd0);

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(9) < 7);
         out_ready = ($urandom_range(9) < 7);
         a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
         @(posedge clk); #1;
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
